// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet receive filter: FSM encoding, header
// layout constants and the saturating counter increment.
package eth_pkg;

  localparam int          ETH_HDR_LEN  = 14;
  localparam logic [47:0] ETH_BCAST    = 48'hFFFF_FFFF_FFFF;
  localparam int          ETH_OFF_DST  = 0;
  localparam int          ETH_OFF_SRC  = 6;
  localparam int          ETH_OFF_TYPE = 12;

  typedef logic [2:0] eth_state_t;

  localparam eth_state_t ST_IDLE    = 3'd0;
  localparam eth_state_t ST_LEN_L   = 3'd1;
  localparam eth_state_t ST_HDR     = 3'd2;
  localparam eth_state_t ST_PAYLOAD = 3'd3;
  localparam eth_state_t ST_DROP    = 3'd4;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/eth_rx_filter.sv
// Pops length-prefixed frames from the receive FIFO, filters on destination
// MAC and EtherType, and streams accepted payload bytes downstream.
module eth_rx_filter
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC       = 48'h7E3C32E74851,
  parameter logic [15:0] ETHERTYPE       = 16'h88B5,
  parameter bit          ACCEPT_ANY_TYPE = 1'b0,
  parameter int          MAX_LEN         = 1514
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rdata,
  input  logic        i_rready,
  output logic        o_rreq,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_sof,
  output logic        o_eof,
  output logic [47:0] o_src_mac,
  output logic [15:0] o_ethertype,
  output logic [15:0] o_cnt_ok,
  output logic [15:0] o_cnt_drop,
  output logic [15:0] o_cnt_runt
);

  localparam logic [15:0] MAX_LEN_W  = 16'(MAX_LEN);
  localparam logic [15:0] HDR_LEN_W  = 16'(ETH_HDR_LEN);
  localparam logic [3:0]  HDR_LAST_W = 4'(ETH_HDR_LEN - 1);

  eth_state_t    r_state;
  logic [7:0]    r_len_hi;
  logic [15:0]   r_rem;
  logic [3:0]    r_idx;
  logic [103:0]  r_hdr;
  logic          r_sof_pend;
  logic          r_done;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_sof;
  logic          r_eof;
  logic [47:0]   r_src_mac;
  logic [15:0]   r_ethertype;
  logic [15:0]   r_cnt_ok;
  logic [15:0]   r_cnt_drop;
  logic [15:0]   r_cnt_runt;

  logic [15:0]   w_len;
  logic [111:0]  w_hdr;
  logic [47:0]   w_dst;
  logic [47:0]   w_src;
  logic [15:0]   w_type;
  logic          w_dst_match;
  logic          w_type_match;
  logic          w_pop;

  // The 14th header byte is still on i_rdata when the match decision is made.
  assign w_len        = {r_len_hi, i_rdata};
  assign w_hdr        = {r_hdr, i_rdata};
  assign w_dst        = w_hdr[(ETH_HDR_LEN - ETH_OFF_DST) * 8 - 1 -: 48];
  assign w_src        = w_hdr[(ETH_HDR_LEN - ETH_OFF_SRC) * 8 - 1 -: 48];
  assign w_type       = w_hdr[(ETH_HDR_LEN - ETH_OFF_TYPE) * 8 - 1 -: 16];
  assign w_dst_match  = (w_dst == BOARD_MAC) || (w_dst == ETH_BCAST);
  assign w_type_match = (w_type == ETHERTYPE) || ACCEPT_ANY_TYPE;

  // FIFO pop decision; in PAYLOAD after eof only the next frame's length may be taken.
  always_comb begin
    w_pop = 1'b0;
    if (i_rst) begin
      w_pop = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_LEN_L, ST_HDR: w_pop = i_rready;
        ST_PAYLOAD: begin
          if (r_done) begin
            w_pop = i_rready && r_valid && i_ready;
          end else begin
            w_pop = i_rready && (!r_valid || i_ready);
          end
        end
        ST_DROP: w_pop = i_rready && (r_rem != 16'd0);
        default: w_pop = 1'b0;
      endcase
    end
  end

  // Frame parser, output register and statistics.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_len_hi    <= 8'd0;
      r_rem       <= 16'd0;
      r_idx       <= 4'd0;
      r_hdr       <= 104'd0;
      r_sof_pend  <= 1'b0;
      r_done      <= 1'b0;
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_src_mac   <= 48'd0;
      r_ethertype <= 16'd0;
      r_cnt_ok    <= 16'd0;
      r_cnt_drop  <= 16'd0;
      r_cnt_runt  <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_len_hi <= i_rdata;
            r_state  <= ST_LEN_L;
          end
        end
        ST_LEN_L: begin
          if (w_pop) begin
            r_rem <= w_len;
            r_idx <= 4'd0;
            if (w_len == 16'd0) begin
              r_state <= ST_IDLE;
            end else if (w_len <= HDR_LEN_W) begin
              r_cnt_runt <= sat_inc(r_cnt_runt);
              r_state    <= ST_DROP;
            end else if (w_len > MAX_LEN_W) begin
              r_cnt_drop <= sat_inc(r_cnt_drop);
              r_state    <= ST_DROP;
            end else begin
              r_state <= ST_HDR;
            end
          end
        end
        ST_HDR: begin
          if (w_pop) begin
            r_hdr <= w_hdr[103:0];
            r_rem <= r_rem - 16'd1;
            r_idx <= r_idx + 4'd1;
            if (r_idx == HDR_LAST_W) begin
              if (w_dst_match && w_type_match) begin
                r_src_mac   <= w_src;
                r_ethertype <= w_type;
                r_cnt_ok    <= sat_inc(r_cnt_ok);
                r_sof_pend  <= 1'b1;
                r_state     <= ST_PAYLOAD;
              end else begin
                r_cnt_drop <= sat_inc(r_cnt_drop);
                r_state    <= ST_DROP;
              end
            end
          end
        end
        ST_PAYLOAD: begin
          if (r_done) begin
            if (r_valid && i_ready) begin
              r_valid <= 1'b0;
              r_sof   <= 1'b0;
              r_eof   <= 1'b0;
              r_done  <= 1'b0;
              if (w_pop) begin
                r_len_hi <= i_rdata;
                r_state  <= ST_LEN_L;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end else if (w_pop) begin
            r_data     <= i_rdata;
            r_valid    <= 1'b1;
            r_sof      <= r_sof_pend;
            r_sof_pend <= 1'b0;
            r_eof      <= (r_rem == 16'd1);
            r_done     <= (r_rem == 16'd1);
            r_rem      <= r_rem - 16'd1;
          end else if (i_ready) begin
            r_valid <= 1'b0;
            r_sof   <= 1'b0;
            r_eof   <= 1'b0;
          end
        end
        ST_DROP: begin
          if (w_pop) begin
            r_rem <= r_rem - 16'd1;
            if (r_rem == 16'd1) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rreq      = w_pop;
  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_sof       = r_sof;
  assign o_eof       = r_eof;
  assign o_src_mac   = r_src_mac;
  assign o_ethertype = r_ethertype;
  assign o_cnt_ok    = r_cnt_ok;
  assign o_cnt_drop  = r_cnt_drop;
  assign o_cnt_runt  = r_cnt_runt;

endmodule

// File: tb/tb_eth_rx_filter.sv
// Directed bench for eth_rx_filter: a queue models the show-ahead receive FIFO
// and accepted output bytes are collected for comparison against expectations.
module tb_eth_rx_filter;

  localparam logic [47:0] BOARD = 48'h7E3C32E74851;
  localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] SRC   = 48'h0A1B2C3D4E5F;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_rdata = 8'h00;
  logic        i_rready = 1'b0;
  logic        o_rreq;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic        o_sof;
  logic        o_eof;
  logic [47:0] o_src_mac;
  logic [15:0] o_ethertype;
  logic [15:0] o_cnt_ok;
  logic [15:0] o_cnt_drop;
  logic [15:0] o_cnt_runt;

  logic [7:0] q[$];
  logic [9:0] rx[$];
  int         pops = 0;
  int         valid_seen = 0;
  bit         gate = 1'b1;
  int         checks = 0;
  int         errors = 0;

  eth_rx_filter #(
    .BOARD_MAC(BOARD), .ETHERTYPE(16'h88B5), .ACCEPT_ANY_TYPE(1'b0), .MAX_LEN(1514)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rdata(i_rdata), .i_rready(i_rready),
    .o_rreq(o_rreq), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_sof(o_sof), .o_eof(o_eof), .o_src_mac(o_src_mac), .o_ethertype(o_ethertype),
    .o_cnt_ok(o_cnt_ok), .o_cnt_drop(o_cnt_drop), .o_cnt_runt(o_cnt_runt)
  );

  always #5 i_clk = ~i_clk;

  // FIFO model: consume on o_rreq at the edge, present the new head shortly after.
  always @(posedge i_clk) begin
    if (o_rreq === 1'b1 && q.size() > 0) begin
      void'(q.pop_front());
      pops++;
    end
    #1;
    i_rready = gate && (q.size() > 0);
    i_rdata  = (q.size() > 0) ? q[0] : 8'h00;
  end

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_valid) valid_seen++;
      if (o_valid && i_ready) rx.push_back({o_sof, o_eof, o_data});
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [15:0] len, input logic [47:0] dst,
                            input logic [15:0] etype, input logic [7:0] first);
    logic [7:0] b;
    q.push_back(len[15:8]);
    q.push_back(len[7:0]);
    for (int i = 0; i < int'(len); i++) begin
      if (i < 6)       b = dst[47 - 8 * i -: 8];
      else if (i < 12) b = SRC[47 - 8 * (i - 6) -: 8];
      else if (i == 12) b = etype[15:8];
      else if (i == 13) b = etype[7:0];
      else             b = first + 8'(i - 14);
      q.push_back(b);
    end
  endtask

  task automatic wait_idle(output bit ok);
    int stable;
    stable = 0;
    ok = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge i_clk);
      if (q.size() == 0 && !o_valid) stable++;
      else stable = 0;
      if (stable >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    q.delete();
    gate = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    rx.delete();
    pops = 0;
    valid_seen = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    checks++;
    if ({o_valid, o_sof, o_eof, o_rreq} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {o_valid, o_sof, o_eof, o_rreq});
    end
    checks++;
    if ({o_data, o_src_mac, o_ethertype} !== 72'd0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {o_data, o_src_mac, o_ethertype});
    end
    checks++;
    if ({o_cnt_ok, o_cnt_drop, o_cnt_runt} !== 48'd0) begin
      errors++; $display("FAIL reset_cnt: got %h want 0", {o_cnt_ok, o_cnt_drop, o_cnt_runt});
    end
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  task automatic test_unicast();
    bit ok;
    do_reset();
    push_frame(16'd20, BOARD, 16'h88B5, 8'h01);
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL unicast_timeout: got busy want idle"); end
    checks++;
    if (rx.size() != 6) begin errors++; $display("FAIL unicast_len: got %0d want 6", rx.size()); end
    for (int j = 0; j < 6 && j < rx.size(); j++) begin
      checks++;
      if (rx[j] !== {j == 0, j == 5, 8'(8'h01 + j)}) begin
        errors++; $display("FAIL unicast_byte%0d: got %h want %h", j, rx[j], {j == 0, j == 5, 8'(8'h01 + j)});
      end
    end
    checks++;
    if (o_src_mac !== SRC) begin errors++; $display("FAIL unicast_src: got %h want %h", o_src_mac, SRC); end
    checks++;
    if (o_ethertype !== 16'h88B5) begin errors++; $display("FAIL unicast_type: got %h want 88b5", o_ethertype); end
    checks++;
    if ({o_cnt_ok, o_cnt_drop, o_cnt_runt} !== {16'd1, 16'd0, 16'd0}) begin
      errors++; $display("FAIL unicast_cnt: got %h want 000100000000", {o_cnt_ok, o_cnt_drop, o_cnt_runt});
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [10:0] prev;
    bit hold;
    do_reset();
    hold = 1'b0;
    prev = 11'd0;
    push_frame(16'd20, BCAST, 16'h88B5, 8'hA0);
    for (int c = 0; c < 80; c++) begin
      @(posedge i_clk);
      #1;
      i_ready = ~i_ready;
      @(negedge i_clk);
      if (hold) begin
        checks++;
        if ({o_valid, o_sof, o_eof, o_data} !== prev) begin
          errors++; $display("FAIL bp_hold: got %h want %h", {o_valid, o_sof, o_eof, o_data}, prev);
        end
      end
      hold = o_valid && !i_ready;
      prev = {o_valid, o_sof, o_eof, o_data};
    end
    @(posedge i_clk);
    #1;
    i_ready = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL bp_timeout: got busy want idle"); end
    checks++;
    if (rx.size() != 6) begin errors++; $display("FAIL bp_len: got %0d want 6", rx.size()); end
    for (int j = 0; j < 6 && j < rx.size(); j++) begin
      checks++;
      if (rx[j] !== {j == 0, j == 5, 8'(8'hA0 + j)}) begin
        errors++; $display("FAIL bp_byte%0d: got %h want %h", j, rx[j], {j == 0, j == 5, 8'(8'hA0 + j)});
      end
    end
    checks++;
    if (o_cnt_ok !== 16'd1) begin errors++; $display("FAIL bp_cnt: got %0d want 1", o_cnt_ok); end
  endtask

  task automatic test_filter();
    bit ok;
    do_reset();
    push_frame(16'd20, 48'h020000000001, 16'h88B5, 8'h10);
    wait_idle(ok);
    checks++;
    if (!ok || pops != 22) begin errors++; $display("FAIL dst_pops: got %0d want 22", pops); end
    checks++;
    if (valid_seen != 0) begin errors++; $display("FAIL dst_valid: got %0d want 0", valid_seen); end
    checks++;
    if ({o_cnt_ok, o_cnt_drop, o_cnt_runt} !== {16'd0, 16'd1, 16'd0}) begin
      errors++; $display("FAIL dst_cnt: got %h want 000000010000", {o_cnt_ok, o_cnt_drop, o_cnt_runt});
    end
    pops = 0;
    push_frame(16'd20, BOARD, 16'h0800, 8'h20);
    wait_idle(ok);
    checks++;
    if (!ok || pops != 22) begin errors++; $display("FAIL type_pops: got %0d want 22", pops); end
    checks++;
    if (valid_seen != 0) begin errors++; $display("FAIL type_valid: got %0d want 0", valid_seen); end
    checks++;
    if ({o_cnt_ok, o_cnt_drop, o_cnt_runt} !== {16'd0, 16'd2, 16'd0}) begin
      errors++; $display("FAIL type_cnt: got %h want 000000020000", {o_cnt_ok, o_cnt_drop, o_cnt_runt});
    end
  endtask

  task automatic test_runt_len();
    bit ok;
    do_reset();
    push_frame(16'd10, BOARD, 16'h88B5, 8'h00);
    wait_idle(ok);
    checks++;
    if (!ok || pops != 12) begin errors++; $display("FAIL runt_pops: got %0d want 12", pops); end
    checks++;
    if ({o_cnt_ok, o_cnt_drop, o_cnt_runt} !== {16'd0, 16'd0, 16'd1}) begin
      errors++; $display("FAIL runt_cnt: got %h want 000000000001", {o_cnt_ok, o_cnt_drop, o_cnt_runt});
    end
    pops = 0;
    push_frame(16'd0, BOARD, 16'h88B5, 8'h00);
    wait_idle(ok);
    checks++;
    if (!ok || pops != 2) begin errors++; $display("FAIL zero_pops: got %0d want 2", pops); end
    checks++;
    if ({o_cnt_ok, o_cnt_drop, o_cnt_runt} !== {16'd0, 16'd0, 16'd1}) begin
      errors++; $display("FAIL zero_cnt: got %h want 000000000001", {o_cnt_ok, o_cnt_drop, o_cnt_runt});
    end
    do_reset();
    push_frame(16'd1600, BOARD, 16'h88B5, 8'h00);
    wait_idle(ok);
    checks++;
    if (!ok || pops != 1602) begin errors++; $display("FAIL big_pops: got %0d want 1602", pops); end
    checks++;
    if (valid_seen != 0) begin errors++; $display("FAIL big_valid: got %0d want 0", valid_seen); end
    checks++;
    if ({o_cnt_ok, o_cnt_drop, o_cnt_runt} !== {16'd0, 16'd1, 16'd0}) begin
      errors++; $display("FAIL big_cnt: got %h want 000000010000", {o_cnt_ok, o_cnt_drop, o_cnt_runt});
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] base;
    do_reset();
    push_frame(16'd20, BOARD, 16'h88B5, 8'h41);
    push_frame(16'd20, BCAST, 16'h88B5, 8'h51);
    repeat (5) @(posedge i_clk);
    gate = 1'b0;
    repeat (3) @(posedge i_clk);
    gate = 1'b1;
    repeat (20) @(posedge i_clk);
    gate = 1'b0;
    repeat (3) @(posedge i_clk);
    gate = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: got busy want idle"); end
    checks++;
    if (rx.size() != 12) begin errors++; $display("FAIL b2b_len: got %0d want 12", rx.size()); end
    for (int j = 0; j < 12 && j < rx.size(); j++) begin
      base = (j < 6) ? 8'h41 : 8'h51;
      checks++;
      if (rx[j] !== {(j % 6) == 0, (j % 6) == 5, 8'(base + 8'(j % 6))}) begin
        errors++; $display("FAIL b2b_byte%0d: got %h want %h", j, rx[j], {(j % 6) == 0, (j % 6) == 5, 8'(base + 8'(j % 6))});
      end
    end
    checks++;
    if (o_cnt_ok !== 16'd2) begin errors++; $display("FAIL b2b_cnt: got %0d want 2", o_cnt_ok); end
  endtask

  task automatic test_reset_midframe();
    bit ok;
    bit seen;
    do_reset();
    seen = 1'b0;
    push_frame(16'd20, BOARD, 16'h88B5, 8'h11);
    for (int c = 0; c < 200; c++) begin
      @(negedge i_clk);
      if (rx.size() >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL mid_reach: got %0d bytes want 2", rx.size()); end
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    q.delete();
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_valid, o_sof, o_eof, o_rreq, o_data} !== 12'd0) begin
      errors++; $display("FAIL mid_ctrl: got %h want 0", {o_valid, o_sof, o_eof, o_rreq, o_data});
    end
    checks++;
    if ({o_cnt_ok, o_cnt_drop, o_cnt_runt, o_src_mac, o_ethertype} !== 112'd0) begin
      errors++; $display("FAIL mid_regs: got %h want 0", {o_cnt_ok, o_cnt_drop, o_cnt_runt, o_src_mac, o_ethertype});
    end
    rx.delete();
    push_frame(16'd20, BCAST, 16'h88B5, 8'h31);
    wait_idle(ok);
    checks++;
    if (!ok || rx.size() != 6) begin errors++; $display("FAIL mid_fresh_len: got %0d want 6", rx.size()); end
    for (int j = 0; j < 6 && j < rx.size(); j++) begin
      checks++;
      if (rx[j] !== {j == 0, j == 5, 8'(8'h31 + j)}) begin
        errors++; $display("FAIL mid_fresh_byte%0d: got %h want %h", j, rx[j], {j == 0, j == 5, 8'(8'h31 + j)});
      end
    end
    checks++;
    if (o_cnt_ok !== 16'd1) begin errors++; $display("FAIL mid_fresh_cnt: got %0d want 1", o_cnt_ok); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_backpressure();
    test_filter();
    test_runt_len();
    test_back_to_back();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
